symbol_rng_level2: RTL and testbench

//  Level-2 symbol source. It sits directly upstream of the level-2 scorer.
//  On request it draws a pseudo-random 4-bit symbol from a free-running LFSR and shows it to the player.
//  It also presents the symbol's encrypted code on rng_op for the scorer to compare against the player's toggles.
//  rng_load is held high for a fixed display window; the scorer waits for rng_load to fall before rearming.
//  The block counts rounds and flags game_done after ROUNDS symbols have been issued.

---
 rtl/game_pkg.sv | 21 ++
 rtl/lfsr8.sv | 32 +++
 rtl/symbol_rng_level2.sv | 119 +++++++++++
 tb/tb_symbol_rng_level2.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared level-2 game definitions: FSM state encodings, default encoder key and
// the symbol encoder used by the RNG and by any scorer model.
package game_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'b00,
        ST_DRAW      = 2'b01,
        ST_LOAD_HOLD = 2'b10,
        ST_READY     = 2'b11
    } state_e;

    localparam logic [3:0] DEFAULT_KEY = 4'b1010;

    // enc(s) = rotate-left-by-one of (s ^ key)
    function automatic logic [3:0] enc(input logic [3:0] s, input logic [3:0] key);
        logic [3:0] t;
        t = s ^ key;
        return {t[2:0], t[3]};
    endfunction

endpackage

// File: rtl/lfsr8.sv
// Free-running 8-bit Fibonacci LFSR (taps 8,6,5,4) that reseeds on reset and
// escapes the all-zero lock-up state by reloading SEED.
module lfsr8 #(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       clock,
    input  logic       reset,
    output logic [7:0] q
);

    logic [7:0] lfsr_q;
    logic [7:0] lfsr_d;

    always_comb begin
        if (lfsr_q == '0) begin
            lfsr_d = SEED;
        end else begin
            lfsr_d = {lfsr_q[6:0], lfsr_q[7] ^ lfsr_q[5] ^ lfsr_q[4] ^ lfsr_q[3]};
        end
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign q = lfsr_q;

endmodule

// File: rtl/symbol_rng_level2.sv
// Level-2 symbol source: draws a non-repeating 4-bit symbol on request, presents
// it with its encrypted code for a fixed load window, and counts game rounds.
module symbol_rng_level2
    import game_pkg::*;
#(
    parameter logic [7:0]  SEED        = 8'hA5,
    parameter logic [3:0]  KEY         = DEFAULT_KEY,
    parameter int unsigned HOLD_CYCLES = 50_000_000,
    parameter int unsigned HOLD_W      = 26,
    parameter int unsigned ROUNDS      = 20
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       clear,
    input  logic       gen_req,
    output logic [3:0] symbol,
    output logic [3:0] rng_op,
    output logic       rng_load,
    output logic [7:0] round_cnt,
    output logic       game_done
);

    logic [7:0]        lfsr;
    logic [3:0]        cand;
    state_e            state_q,    state_d;
    logic [3:0]        symbol_q,   symbol_d;
    logic [3:0]        rng_op_q,   rng_op_d;
    logic              rng_load_q, rng_load_d;
    logic [HOLD_W-1:0] hold_q,     hold_d;
    logic [7:0]        round_q,    round_d;
    logic              done_q,     done_d;

    lfsr8 #(.SEED(SEED)) u_lfsr (
        .clock (clock),
        .reset (reset),
        .q     (lfsr)
    );

    // Fall back to the upper nibble, then to symbol+1, so a draw never repeats.
    always_comb begin
        cand = lfsr[3:0];
        if (cand == symbol_q) begin
            cand = lfsr[7:4];
            if (cand == symbol_q) begin
                cand = symbol_q + 4'd1;
            end
        end
    end

    always_comb begin
        state_d    = state_q;
        symbol_d   = symbol_q;
        rng_op_d   = rng_op_q;
        rng_load_d = rng_load_q;
        hold_d     = hold_q;
        round_d    = round_q;
        done_d     = done_q;
        case (state_q)
            ST_IDLE, ST_READY: begin
                if (gen_req && !done_q) begin
                    state_d = ST_DRAW;
                end
            end
            ST_DRAW: begin
                symbol_d   = cand;
                rng_op_d   = enc(cand, KEY);
                rng_load_d = 1'b1;
                hold_d     = HOLD_W'(HOLD_CYCLES - 1);
                round_d    = round_q + 8'd1;
                done_d     = ((round_q + 8'd1) == 8'(ROUNDS));
                state_d    = ST_LOAD_HOLD;
            end
            ST_LOAD_HOLD: begin
                if (hold_q == '0) begin
                    rng_load_d = 1'b0;
                    state_d    = ST_READY;
                end else begin
                    hold_d = hold_q - 1'b1;
                end
            end
            default: begin
                state_d    = ST_IDLE;
                symbol_d   = '0;
                rng_op_d   = '0;
                rng_load_d = 1'b0;
                hold_d     = '0;
                round_d    = '0;
                done_d     = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset || clear) begin
            state_q    <= ST_IDLE;
            symbol_q   <= '0;
            rng_op_q   <= '0;
            rng_load_q <= 1'b0;
            hold_q     <= '0;
            round_q    <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            symbol_q   <= symbol_d;
            rng_op_q   <= rng_op_d;
            rng_load_q <= rng_load_d;
            hold_q     <= hold_d;
            round_q    <= round_d;
            done_q     <= done_d;
        end
    end

    assign symbol    = symbol_q;
    assign rng_op    = rng_op_q;
    assign rng_load  = rng_load_q;
    assign round_cnt = round_q;
    assign game_done = done_q;

endmodule

// File: tb/tb_symbol_rng_level2.sv
// Directed bench for symbol_rng_level2 with a short hold window and a 3-round game.
module tb_symbol_rng_level2;

    localparam int unsigned HOLD = 4;
    localparam int unsigned RND  = 3;

    logic       clock   = 1'b0;
    logic       reset   = 1'b0;
    logic       clear   = 1'b0;
    logic       gen_req = 1'b0;
    logic [3:0] symbol;
    logic [3:0] rng_op;
    logic       rng_load;
    logic [7:0] round_cnt;
    logic       game_done;

    int errors = 0;
    int checks = 0;

    logic [7:0] m_lfsr;
    logic [3:0] m_sym    = 4'd0;
    int         m_rounds = 0;

    symbol_rng_level2 #(
        .SEED        (8'hA5),
        .KEY         (4'b1010),
        .HOLD_CYCLES (HOLD),
        .HOLD_W      (3),
        .ROUNDS      (RND)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .clear     (clear),
        .gen_req   (gen_req),
        .symbol    (symbol),
        .rng_op    (rng_op),
        .rng_load  (rng_load),
        .round_cnt (round_cnt),
        .game_done (game_done)
    );

    always #5 clock = ~clock;

    function automatic logic [7:0] step(input logic [7:0] l);
        if (l == 8'h00) return 8'hA5;
        return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    endfunction

    function automatic logic [3:0] tb_enc(input logic [3:0] s);
        logic [3:0] t;
        t = s ^ 4'b1010;
        return {t[2:0], t[3]};
    endfunction

    function automatic logic [3:0] pick(input logic [7:0] l, input logic [3:0] prev);
        if (l[3:0] != prev) return l[3:0];
        if (l[7:4] != prev) return l[7:4];
        return prev + 4'd1;
    endfunction

    always @(posedge clock) m_lfsr <= !reset ? 8'hA5 : step(m_lfsr);

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Request at the current negedge; optionally poke gen_req during DRAW and LOAD_HOLD.
    task automatic draw_and_check(input string tag, input bit poke);
        logic [7:0] l;
        logic [3:0] es;
        gen_req = 1'b1;
        @(negedge clock);
        l       = m_lfsr;
        gen_req = poke;
        es      = pick(l, m_sym);
        @(negedge clock);
        gen_req = 1'b0;
        m_sym   = es;
        m_rounds++;
        check({tag, ".sym"},   32'(symbol),    32'(es));
        check({tag, ".op"},    32'(rng_op),    32'(tb_enc(es)));
        check({tag, ".round"}, 32'(round_cnt), 32'(m_rounds));
        check({tag, ".done"},  32'(game_done), 32'(m_rounds == RND));
        check({tag, ".load1"}, 32'(rng_load),  32'd1);
        for (int k = 2; k <= HOLD; k++) begin
            gen_req = poke && (k == 3);
            @(negedge clock);
            check({tag, ".loadk"}, 32'(rng_load), 32'd1);
        end
        gen_req = poke;
        @(negedge clock);
        check({tag, ".load0"},   32'(rng_load),  32'd0);
        check({tag, ".roundst"}, 32'(round_cnt), 32'(m_rounds));
        gen_req = 1'b0;
        @(negedge clock);
        check({tag, ".idle"}, 32'(rng_load), 32'd0);
    endtask

    task automatic wait_lfsr(input string tag, input logic [7:0] mask, input logic [7:0] val);
        bit found;
        found = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if ((step(m_lfsr) & mask) == val) begin
                found = 1'b1;
                break;
            end
            @(negedge clock);
        end
        check({tag, ".found"}, 32'(found), 32'd1);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(negedge clock);
        clear    = 1'b0;
        m_sym    = 4'd0;
        m_rounds = 0;
    endtask

    initial begin
        bit drawn;
        bit clear_prev;

        // Reset state and free-running LFSR
        repeat (2) @(negedge clock);
        check("rst.sym",   32'(symbol),    32'd0);
        check("rst.op",    32'(rng_op),    32'd0);
        check("rst.load",  32'(rng_load),  32'd0);
        check("rst.round", 32'(round_cnt), 32'd0);
        check("rst.done",  32'(game_done), 32'd0);
        check("rst.lfsr",  32'(dut.lfsr),  32'h0A5);
        reset = 1'b1;
        @(negedge clock);
        check("run.lfsr1", 32'(dut.lfsr), 32'h04A);
        @(negedge clock);
        check("run.lfsr2", 32'(dut.lfsr), 32'h095);
        check("run.load",  32'(rng_load), 32'd0);
        check("run.sym",   32'(symbol),   32'd0);

        // Basic draw; first symbol after reset cannot be 0
        draw_and_check("t2", 1'b0);
        check("t2.nonzero", 32'(symbol != 4'd0), 32'd1);
        do_clear();
        check("clr.round", 32'(round_cnt), 32'd0);
        check("clr.sym",   32'(symbol),    32'd0);

        // Double collision: prev symbol 7 with lfsr 0x77 falls through to 8
        wait_lfsr("t3a", 8'h0F, 8'h07);
        draw_and_check("t3a", 1'b0);
        check("t3a.seven", 32'(symbol), 32'd7);
        wait_lfsr("t3b", 8'hFF, 8'h77);
        draw_and_check("t3b", 1'b0);
        check("t3b.eight", 32'(symbol), 32'd8);
        check("t3b.enc8",  32'(rng_op), 32'h4);

        // Third round with dropped requests ends the game
        draw_and_check("t4", 1'b1);
        check("t5.done",  32'(game_done), 32'd1);
        check("t5.round", 32'(round_cnt), 32'd3);
        gen_req = 1'b1;
        @(negedge clock);
        gen_req = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            check("t5.noload", 32'(rng_load), 32'd0);
        end
        check("t5.keepsym", 32'(symbol), 32'(m_sym));
        do_clear();
        check("t5.clrround", 32'(round_cnt), 32'd0);
        check("t5.clrdone",  32'(game_done), 32'd0);
        check("t5.noreseed", 32'(dut.lfsr),  32'(m_lfsr));

        // Reset in the middle of a load window
        gen_req = 1'b1;
        @(negedge clock);
        gen_req = 1'b0;
        @(negedge clock);
        check("t6.loadon", 32'(rng_load), 32'd1);
        reset = 1'b0;
        @(negedge clock);
        reset    = 1'b1;
        m_sym    = 4'd0;
        m_rounds = 0;
        check("t6r.load",  32'(rng_load),  32'd0);
        check("t6r.sym",   32'(symbol),    32'd0);
        check("t6r.op",    32'(rng_op),    32'd0);
        check("t6r.round", 32'(round_cnt), 32'd0);
        check("t6r.lfsr",  32'(dut.lfsr),  32'h0A5);

        // Clear in the middle of a load window, then the FSM must accept a new request
        gen_req = 1'b1;
        @(negedge clock);
        gen_req = 1'b0;
        repeat (2) @(negedge clock);
        check("t6c.loadon", 32'(rng_load), 32'd1);
        do_clear();
        check("t6c.load",  32'(rng_load),  32'd0);
        check("t6c.round", 32'(round_cnt), 32'd0);
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check("t6c.stay", 32'(rng_load), 32'd0);
        end
        draw_and_check("t6c.after", 1'b0);

        // Random traffic: rng_op always matches the encoded symbol once drawn
        do_clear();
        drawn      = 1'b0;
        clear_prev = 1'b0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clock);
            if (clear_prev) drawn = 1'b0;
            if (rng_load)   drawn = 1'b1;
            if (drawn) check("rnd.enc",  32'(rng_op), 32'(tb_enc(symbol)));
            else       check("rnd.zero", 32'(rng_op), 32'd0);
            check("rnd.rounds", 32'(round_cnt <= 8'(RND)), 32'd1);
            gen_req    = ($urandom_range(0, 7) == 0);
            clear      = ($urandom_range(0, 199) == 0);
            clear_prev = clear;
        end
        gen_req = 1'b0;
        clear   = 1'b0;
        @(negedge clock);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
